parity_button_ctrl: RTL and testbench

- Front-end stage that turns the board's raw, bouncing pushbuttons into clean control levels.
- Outputs are EVEN, ODD, PAUSE and a counter-reset level, consumed directly by the 3-bit parity counter / 7-segment stage downstream.
- Also produces a one-cycle count-enable tick so the counter advances at a human-visible rate.
- Everything runs in the single CLK domain.

---
 rtl/parity_pkg.sv | 10 +
 rtl/parity_button_ctrl_if.sv | 9 +
 rtl/parity_debounce_cell.sv | 28 ++
 rtl/parity_button_ctrl.sv | 47 ++++
 tb/tb_parity_button_ctrl.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared constants for the parity button front end
package parity_pkg;
  localparam int DB_COUNT_DEFAULT = 500000;
  localparam int DIV_DEFAULT = 50000000;
  localparam int BTN_I_EVEN = 0;
  localparam int BTN_I_ODD = 1;
  localparam int BTN_I_PAUSE = 2;
  localparam int BTN_I_CLR = 3;
  localparam int N_BTN = 4;
endpackage

// File: rtl/parity_button_ctrl_if.sv
// parity_button_ctrl_if: raw buttons in, clean control levels and tick out
interface parity_button_ctrl_if;
  logic BTN_EVEN, BTN_ODD, BTN_PAUSE, BTN_CLR;
  logic EVEN, ODD, PAUSE, CNT_RST, TICK;
  modport master(output BTN_EVEN, BTN_ODD, BTN_PAUSE, BTN_CLR,
                 input EVEN, ODD, PAUSE, CNT_RST, TICK);
  modport slave(input BTN_EVEN, BTN_ODD, BTN_PAUSE, BTN_CLR,
                output EVEN, ODD, PAUSE, CNT_RST, TICK);
endinterface

// File: rtl/parity_debounce_cell.sv
// parity_debounce_cell: 2-flop synchroniser, stability counter and press detect
module parity_debounce_cell #(
  parameter int DB_COUNT = parity_pkg::DB_COUNT_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic stable,
  output logic press
);
  localparam int DB_W = $clog2(DB_COUNT + 1);
  logic [1:0] sync;
  logic [DB_W-1:0] cnt;
  logic done;
  assign done = cnt == DB_W'(DB_COUNT - 1);
  // press fires in the same cycle stable is about to rise, so toggles land with it
  assign press = sync[1] & ~stable & done;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sync <= '0;
      cnt <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] == stable || done) ? '0 : cnt + 1'b1;
      if (sync[1] != stable && done) stable <= sync[1];
    end
endmodule

// File: rtl/parity_button_ctrl.sv
// parity_button_ctrl: debounced toggle latches, counter clear level and count-enable tick
module parity_button_ctrl
  import parity_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEFAULT,
  parameter int DIV = DIV_DEFAULT
) (
  input logic CLK,
  input logic RESET,
  parity_button_ctrl_if.slave bus
);
  localparam int DIV_W = $clog2(DIV);
  logic [N_BTN-1:0] raw, stable, press;
  logic clear, even, odd, pause, tick, unused_stable;
  logic [DIV_W-1:0] pre;
  assign raw[BTN_I_EVEN] = bus.BTN_EVEN;
  assign raw[BTN_I_ODD] = bus.BTN_ODD;
  assign raw[BTN_I_PAUSE] = bus.BTN_PAUSE;
  assign raw[BTN_I_CLR] = bus.BTN_CLR;
  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    parity_debounce_cell #(.DB_COUNT(DB_COUNT)) u_db (
      .CLK(CLK), .RESET(RESET), .raw(raw[g]), .stable(stable[g]), .press(press[g])
    );
  end
  // include the rising edge so the latches clear in the same cycle CNT_RST rises
  assign clear = stable[BTN_I_CLR] | press[BTN_I_CLR];
  assign unused_stable = ^stable[BTN_I_PAUSE:BTN_I_EVEN];
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      even <= 1'b0;
      odd <= 1'b0;
      pause <= 1'b0;
      pre <= '0;
      tick <= 1'b0;
    end else begin
      even <= ~clear & (even ^ press[BTN_I_EVEN]);
      odd <= ~clear & (odd ^ press[BTN_I_ODD]);
      pause <= ~clear & (pause ^ press[BTN_I_PAUSE]);
      pre <= (clear || pre == DIV_W'(DIV - 1)) ? '0 : pre + 1'b1;
      tick <= ~clear & (pre == DIV_W'(DIV - 1));
    end
  assign bus.EVEN = even;
  assign bus.ODD = odd;
  assign bus.PAUSE = pause;
  assign bus.CNT_RST = stable[BTN_I_CLR];
  assign bus.TICK = tick;
endmodule

// File: tb/tb_parity_button_ctrl.sv
// tb_parity_button_ctrl: table-driven per-cycle vectors with a scoreboard queue
module tb_parity_button_ctrl;
  import parity_pkg::*;
  typedef struct {
    logic rst_first;
    logic [3:0] rst_btn;
    logic [3:0] btn;
    logic [3:0] want;
    string name;
  } vec_t;
  typedef struct {
    logic [4:0] want;
    string name;
  } sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  parity_button_ctrl_if bus();
  parity_button_ctrl #(.DB_COUNT(4), .DIV(8)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  vec_t vecs[$];
  sb_t sb[$];
  int n_tests = 0, n_fail = 0, tn = 0, ticks = 0;
  logic prev_c = 1'b0;

  function automatic void add(input logic r, input logic [3:0] rb, input logic [3:0] b,
                              input logic [3:0] w, input string nm);
    vec_t v;
    v.rst_first = r;
    v.rst_btn = rb;
    v.btn = b;
    v.want = w;
    v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic logic [4:0] outs();
    return {bus.TICK, bus.CNT_RST, bus.PAUSE, bus.ODD, bus.EVEN};
  endfunction

  task automatic check(input string nm, input logic [4:0] got, input logic [4:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got {tick,cnt_rst,pause,odd,even}=%b want %b at %0t", nm, got, want, $time);
    end
  endtask

  task automatic drive(input logic [3:0] b);
    bus.BTN_EVEN = b[BTN_I_EVEN];
    bus.BTN_ODD = b[BTN_I_ODD];
    bus.BTN_PAUSE = b[BTN_I_PAUSE];
    bus.BTN_CLR = b[BTN_I_CLR];
  endtask

  task automatic do_reset(input logic [3:0] b);
    rst = 1'b1;
    drive(b);
    repeat (3) begin
      @(posedge clk); #1;
      check("in_reset", outs(), 5'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    tn = 0;
    prev_c = 1'b0;
  endtask

  // expected TICK: every 8th edge, restarting from the edge where clear drops
  task automatic step(input vec_t v);
    sb_t s;
    logic c;
    drive(v.btn);
    c = v.want[BTN_I_CLR];
    tn = (c || prev_c) ? 0 : tn + 1;
    prev_c = c;
    s.want = {tn != 0 && tn % 8 == 0, v.want};
    s.name = v.name;
    sb.push_back(s);
    @(posedge clk); #1;
    s = sb.pop_front();
    check(s.name, outs(), s.want);
    if (v.name == "tick_run" && bus.TICK) ticks++;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] pat;
    logic [3:0] b, w;
    pat = 10'b1111101101;
    drive(4'b0);
    for (int k = 1; k <= 8; k++)
      add(k == 1, 4'b1111, 4'b0111, k >= 6 ? 4'b0111 : 4'b0000, "rst_release");
    for (int k = 1; k <= 24; k++) begin
      b = '0;
      w = '0;
      b[BTN_I_EVEN] = k <= 10 ? pat[k-1] : k <= 14;
      w[BTN_I_EVEN] = k >= 11;
      add(k == 1, 4'b0, b, w, "bounce");
    end
    for (int k = 1; k <= 40; k++) begin
      b = '0;
      w = '0;
      b[BTN_I_ODD] = k <= 10 || (k >= 21 && k <= 30);
      w[BTN_I_ODD] = k >= 6 && k <= 25;
      add(k == 1, 4'b0, b, w, "odd_toggle");
    end
    for (int k = 1; k <= 8; k++) begin
      b = '0;
      w = '0;
      b[BTN_I_EVEN] = 1'b1;
      b[BTN_I_ODD] = 1'b1;
      w[BTN_I_EVEN] = k >= 6;
      w[BTN_I_ODD] = k >= 6;
      add(k == 1, 4'b0, b, w, "simultaneous");
    end
    for (int k = 1; k <= 40; k++) begin
      b = '0;
      w = '0;
      b[BTN_I_EVEN] = k <= 6;
      b[BTN_I_PAUSE] = k <= 6 || (k >= 15 && k <= 22);
      b[BTN_I_CLR] = k >= 13 && k <= 24;
      w[BTN_I_EVEN] = k >= 6 && k <= 17;
      w[BTN_I_PAUSE] = k >= 6 && k <= 17;
      w[BTN_I_CLR] = k >= 18 && k <= 29;
      add(k == 1, 4'b0, b, w, "clear");
    end
    for (int k = 1; k <= 40; k++) add(k == 1, 4'b0, 4'b0, 4'b0, "tick_run");
    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset(vecs[i].rst_btn);
      step(vecs[i]);
    end
    n_tests++;
    if (ticks != 5) begin
      n_fail++;
      $display("FAIL tick_count: got %0d pulses want 5", ticks);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
